// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle control sequencer for the RV32I core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives datapath
// selects and enables combinationally from the state register and IR, and
// keeps free-running cycle and retired-instruction counters.
module rv32i_mc_ctrl #(
  parameter int unsigned RESET_PC_HOLD = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  typedef enum logic [2:0] {
    StBoot   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6,
    StTrap   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    ClsR, ClsI, ClsLoad, ClsStore, ClsBranch, ClsJal, ClsJalr,
    ClsLui, ClsAuipc, ClsFence, ClsSystem, ClsIllegal
  } cls_e;

  localparam logic [3:0] BootLast = 4'(RESET_PC_HOLD - 1);

  state_e     state_q, state_d;
  logic [3:0] boot_cnt_q, boot_cnt_d;
  cls_e       cls;
  logic       rd_zero;

  // Only the opcode and rd fields steer sequencing; the rest belongs to immgen/ALU.
  logic unused_inst;
  assign unused_inst = ^inst[31:12];

  assign rd_zero = (inst[11:7] == 5'd0);
  assign state   = state_q;

  // Classify the instruction held in IR by its major opcode.
  always_comb begin
    cls = ClsIllegal;
    if (inst[1:0] == 2'b11) begin
      case (inst[6:2])
        5'b01100: cls = ClsR;
        5'b00100: cls = ClsI;
        5'b00000: cls = ClsLoad;
        5'b01000: cls = ClsStore;
        5'b11000: cls = ClsBranch;
        5'b11011: cls = ClsJal;
        5'b11001: cls = ClsJalr;
        5'b01101: cls = ClsLui;
        5'b00101: cls = ClsAuipc;
        5'b00011: cls = ClsFence;
        5'b11100: cls = ClsSystem;
        default:  cls = ClsIllegal;
      endcase
    end
  end

  // Next-state and boot hold counter.
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    unique case (state_q)
      StBoot: begin
        boot_cnt_d = boot_cnt_q + 4'd1;
        if (boot_cnt_q == BootLast) state_d = StFetch;
      end
      StFetch: begin
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        case (cls)
          ClsSystem:  state_d = StHalt;
          ClsIllegal: state_d = StTrap;
          default:    state_d = StExec;
        endcase
      end
      StExec: begin
        case (cls)
          ClsBranch, ClsFence: state_d = StFetch;
          ClsLoad, ClsStore:   state_d = StMem;
          default:             state_d = StWb;
        endcase
      end
      StMem: begin
        if (mem_ready) state_d = (cls == ClsStore) ? StFetch : StWb;
      end
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      StTrap:  state_d = StTrap;
      default: state_d = StTrap;
    endcase
  end

  // State register; reset drops straight back to BOOT from anywhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      boot_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end

  // Datapath controls decoded from state and instruction class.
  always_comb begin
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'd0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = 2'd0;
    halted       = 1'b0;
    illegal      = 1'b0;

    // No ALU output register: operand selects stay valid through MEM and WB
    // so the address and the AUIPC result remain on the ALU output.
    if (state_q == StExec || state_q == StMem || state_q == StWb) begin
      alu_a_sel = (cls == ClsAuipc) || (cls == ClsJal);
      alu_b_sel = (cls == ClsI) || (cls == ClsLoad) || (cls == ClsStore) ||
                  (cls == ClsJalr) || (cls == ClsAuipc) || (cls == ClsJal);
    end

    unique case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      StExec: begin
        if (cls == ClsBranch) begin
          pc_we  = 1'b1;
          pc_src = br_taken ? 2'd1 : 2'd0;
        end else if (cls == ClsFence) begin
          pc_we = 1'b1;
        end
      end
      StMem: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls == ClsStore);
        pc_we        = (cls == ClsStore) && mem_ready;
      end
      StWb: begin
        rf_we = !rd_zero;
        pc_we = 1'b1;
        case (cls)
          ClsLoad:         wb_sel = 2'd1;
          ClsJal, ClsJalr: wb_sel = 2'd2;
          ClsLui:          wb_sel = 2'd3;
          default:         wb_sel = 2'd0;
        endcase
        case (cls)
          ClsJal:  pc_src = 2'd1;
          ClsJalr: pc_src = 2'd2;
          default: pc_src = 2'd0;
        endcase
      end
      StHalt: halted = 1'b1;
      StTrap: illegal = 1'b1;
      default: ;
    endcase
  end

  // Performance counters; retirement is the PC update that ends an instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (pc_we && (state_q == StExec || state_q == StMem || state_q == StWb)) begin
        instret_cnt <= instret_cnt + 32'd1;
      end
    end
  end

endmodule

// File: doc/rv32i_mc_ctrl.md
Name: rv32i_mc_ctrl

Overview:
Multi-cycle control sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback. In each state it drives the datapath selects and enables: PC, IR, register file, ALU operand muxes and the memory request. It also applies the memory handshake and maintains cycle and retired-instruction counters. Immediate decode stays in the existing combinational immediate generator; this block only sequences its use.

Parameters:
- RESET_PC_HOLD, 1, number of BOOT cycles after reset release before the first FETCH (1..15).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inst  in  32  current IR contents; stable from DECODE until the next FETCH completes.
- mem_ready  in  1  memory completes the current request this cycle.
- br_taken  in  1  branch comparison result from the ALU, valid in EXEC.
- ir_we  out  1  load IR from memory read data.
- pc_we  out  1  update PC.
- pc_src  out  2  0 = PC+4, 1 = PC+imm, 2 = (rs1+imm)&~1.
- mem_req  out  1  memory request.
- mem_we  out  1  store.
- mem_addr_sel  out  1  0 = PC, 1 = ALU result.
- alu_a_sel  out  1  0 = rs1, 1 = PC.
- alu_b_sel  out  1  0 = rs2, 1 = imm.
- rf_we  out  1  register file write.
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4, 3 = imm.
- state  out  3  current state, for debug.
- halted  out  1  core stopped on SYSTEM.
- illegal  out  1  core stopped on an illegal opcode.
- cycle_cnt  out  32  free-running cycle count.
- instret_cnt  out  32  retired instruction count.

Behaviour:
- Reset (rst_n low, async): state = BOOT; counter = 0; cycle_cnt = 0; instret_cnt = 0; every control output = 0.
- Outputs are combinational from the state register and inst. The state register and counters are the only flops.
- State encoding: BOOT = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, HALT = 6, TRAP = 7.
- BOOT: hold RESET_PC_HOLD cycles with all outputs 0, then go to FETCH.
- FETCH: mem_req = 1, mem_addr_sel = 0.
  - Stay in FETCH while mem_ready = 0.
  - On mem_ready = 1: ir_we = 1 in that same cycle, then go to DECODE.
- DECODE: single cycle, no enables asserted. Classify by inst[6:2]:
  - 01100 R-type, 00100 I-type ALU, 00000 load, 01000 store, 11000 branch, 11011 JAL, 11001 JALR, 01101 LUI, 00101 AUIPC, 00011 FENCE: go to EXEC.
  - 11100 SYSTEM: go to HALT.
  - inst[1:0] != 11, or any other opcode: go to TRAP.
- EXEC operand selects per class:
  - R-type: a = rs1, b = rs2.
  - I-type, load, store, JALR: a = rs1, b = imm.
  - AUIPC, JAL: a = PC, b = imm.
  - Branch: a = rs1, b = rs2.
- EXEC next state:
  - Branch: pc_we = 1, pc_src = br_taken ? 1 : 0, go to FETCH.
  - FENCE: pc_we = 1, pc_src = 0, go to FETCH.
  - Load or store: go to MEM.
  - All other classes: go to WB.
- MEM: mem_req = 1, mem_addr_sel = 1, mem_we = 1 for store. alu_a_sel and alu_b_sel held at their EXEC values.
  - Stay in MEM while mem_ready = 0.
  - Store with mem_ready = 1: pc_we = 1, pc_src = 0, go to FETCH.
  - Load with mem_ready = 1: go to WB.
- WB:
  - rf_we = 1 unless rd (inst[11:7]) == 0.
  - wb_sel: ALU for R-type, I-type and AUIPC; memory data for load; PC+4 for JAL and JALR; imm for LUI.
  - pc_we = 1, pc_src: 1 for JAL, 2 for JALR, 0 for everything else. Then go to FETCH.
- instret_cnt increments by 1 on every cycle where pc_we = 1 and the state is EXEC, MEM or WB. Both counters wrap modulo 2^32.
- cycle_cnt increments every cycle after reset, including in HALT and TRAP.
- HALT and TRAP are absorbing; only reset exits them.
  - HALT: halted = 1, every enable = 0.
  - TRAP: illegal = 1, every enable = 0.
- mem_req stays high and its address select stays stable until the cycle mem_ready is seen. mem_ready while mem_req = 0 is ignored.
- Latency with zero wait states, counting the ir_we cycle as cycle 1:
  - ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - Branch, FENCE: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Reset asserted mid-request drops mem_req immediately; no partial state survives.

Test Plan:
- Reset release with RESET_PC_HOLD = 1 and mem_ready tied high: BOOT for 1 cycle. Then issue ADDI x1,x0,5 (0x00500093): FETCH→DECODE→EXEC→WB, with rf_we = 1, wb_sel = 0, alu_b_sel = 1. instret_cnt = 1 after WB.
- LW x2,0(x1) (0x0000A103) with mem_ready held low 3 cycles in MEM: mem_req = 1 and mem_addr_sel = 1 for 4 cycles, then WB with wb_sel = 1.
- BEQ (0x00000463) with br_taken = 1: EXEC asserts pc_we = 1, pc_src = 1, returns to FETCH. With br_taken = 0: pc_src = 0. No rf_we in either case.
- JALR x0,0(x1) (0x00008067): WB has rf_we = 0 (rd = 0), pc_src = 2, pc_we = 1.
- inst = 0x00000000: DECODE goes to TRAP, illegal = 1 and stays 1. ECALL (0x00000073) goes to HALT with halted = 1. cycle_cnt keeps counting in both; instret_cnt freezes.
- Assert rst_n low while in MEM with mem_req = 1: mem_req falls asynchronously, state = 0, both counters = 0.
